muldiv_unit: RTL and testbench



---
 rtl/muldiv_pkg.sv | 18 +
 rtl/muldiv_unit.sv | 152 +++++++++++++++
 tb/tb_muldiv_unit.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// control states and the iteration count.
package muldiv_pkg;

  localparam int ITER = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit. Owns HI/LO, computes
// mult/multu/div/divu in 32 iterations on magnitudes, then fixes signs.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             mthi,
  input  logic             mtlo,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(ITER);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [1:0]           op_q, op_d;
  logic                 sign_res_q, sign_res_d;   // product / quotient sign
  logic                 sign_rem_q, sign_rem_d;   // remainder sign
  logic                 div0_q, div0_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;             // shared working register
  logic [WIDTH-1:0]     opb_q, opb_d;             // multiplicand / divisor
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;

  logic                 op_signed;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_rem;
  logic                 div_ok;
  logic [WIDTH-1:0]     div_sub;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   prod_fix;

  // One iteration of each datapath plus operand magnitudes for launch.
  always_comb begin
    op_signed = ~op[0];
    mag_a     = (op_signed && A[WIDTH-1]) ? -A : A;
    mag_b     = (op_signed && B[WIDTH-1]) ? -B : B;

    // Shift-add: low half holds the remaining multiplier bits.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide: shift in the next dividend bit, subtract if it fits.
    // The remainder is always below the divisor, so the difference fits WIDTH bits.
    div_rem  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ok   = (div_rem >= {1'b0, opb_q});
    div_sub  = div_rem[WIDTH-1:0] - opb_q;
    div_next = {div_ok ? div_sub : div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], div_ok};

    prod_fix = sign_res_q ? -acc_q : acc_q;
  end

  // Next-state, datapath and HI/LO write-path control.
  always_comb begin
    // NOTE: every _d defaults to its _q first so no path through the case infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    sign_res_d = sign_res_q;
    sign_rem_d = sign_rem_q;
    div0_d     = div0_q;
    acc_d      = acc_q;
    opb_d      = opb_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d       = op;
          acc_d      = {{WIDTH{1'b0}}, mag_a};
          opb_d      = mag_b;
          sign_res_d = op_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
          sign_rem_d = op_signed & A[WIDTH-1];
          div0_d     = op[1] & (B == '0);
          cnt_d      = CW'(ITER - 1);
          state_d    = RUN;
        end else begin
          if (mthi) hi_d = A;
          if (mtlo) lo_d = A;
        end
      end
      RUN: begin
        acc_d = op_q[1] ? div_next : mul_next;
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      FIX: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (!op_q[1]) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (!div0_q) begin
          lo_d = sign_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
          hi_d = sign_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      sign_res_q <= 1'b0;
      sign_rem_q <= 1'b0;
      div0_q     <= 1'b0;
      acc_q      <= '0;
      opb_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values together.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      sign_res_q <= sign_res_d;
      sign_rem_q <= sign_rem_d;
      div0_q     <= div0_d;
      acc_q      <= acc_d;
      opb_q      <= opb_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: inputs driven and outputs sampled on the
// falling edge, expected values hand-computed.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A, B;
  logic        mthi, mtlo;
  logic [31:0] HI, LO;
  logic        busy, done;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .start(start), .op(op), .A(A), .B(B),
    .mthi(mthi), .mtlo(mtlo), .HI(HI), .LO(LO), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Launch an op at the current falling edge and wait (bounded) for done.
  // mode 0: plain; 1: mthi+start injected mid-RUN; 2: reset mid-RUN;
  // 3: mthi asserted together with start. lat = falling edges until done
  // (-1 when reset was applied), nbusy = falling edges with busy high,
  // hi_k = HI one edge after launch.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int mode, output int lat, output int nbusy,
                        output logic [31:0] hi_k);
    op = o; A = a; B = b; start = 1'b1;
    mthi = (mode == 3);
    @(negedge CLK);
    start = 1'b0; mthi = 1'b0;
    lat = 1; nbusy = busy ? 1 : 0; hi_k = HI;
    while (!done && lat < 40) begin
      if (mode == 1 && lat == 10) begin
        mthi = 1'b1; start = 1'b1; A = 32'h0000_DEAD; B = 32'h1; op = OP_DIVU;
      end else begin
        mthi = 1'b0; start = 1'b0;
      end
      if (mode == 2 && lat == 16) begin
        RST = 1'b1;
        #1;
        lat = -1;
        break;
      end
      @(negedge CLK);
      lat++;
      if (busy) nbusy++;
    end
  endtask

  int          lat, nb;
  logic [31:0] hk;

  initial begin
    RST = 1'b1; start = 1'b0; op = '0; A = '0; B = '0; mthi = 1'b0; mtlo = 1'b0;
    repeat (2) @(negedge CLK);
    check("reset_hi", HI, 32'h0);
    check("reset_lo", LO, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_done", {31'b0, done}, 32'h0);
    RST = 1'b0;
    @(negedge CLK);

    // multu max*max, latency and busy length
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, nb, hk);
    check("multu_lat", lat, 34);
    check("multu_busy_cycles", nb, 33);
    check("multu_hi", HI, 32'hFFFF_FFFE);
    check("multu_lo", LO, 32'h0000_0001);
    @(negedge CLK);
    check("done_drop", {31'b0, done}, 32'h0);

    // signed multiplies, second issued back-to-back in the done cycle
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'h7, 0, lat, nb, hk);
    check("mult_neg_hi", HI, 32'hFFFF_FFFF);
    check("mult_neg_lo", LO, 32'hFFFF_FFEB);
    run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, 0, lat, nb, hk);
    check("mult_b2b_lat", lat, 34);
    check("mult_min_hi", HI, 32'h4000_0000);
    check("mult_min_lo", LO, 32'h0);

    // divides
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'h2, 0, lat, nb, hk);
    check("div_neg_lo", LO, 32'hFFFF_FFFD);
    check("div_neg_hi", HI, 32'hFFFF_FFFF);
    run_op(OP_DIVU, 32'd100, 32'd7, 3, lat, nb, hk);
    check("start_beats_mthi", hk, 32'hFFFF_FFFF);
    check("divu_lo", LO, 32'd14);
    check("divu_hi", HI, 32'd2);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, nb, hk);
    check("div_wrap_lo", LO, 32'h8000_0000);
    check("div_wrap_hi", HI, 32'h0);

    // mthi/mtlo preload, then divide by zero leaves them intact
    mthi = 1'b1; A = 32'h11;
    @(negedge CLK);
    mthi = 1'b0;
    check("mthi_write", HI, 32'h11);
    mtlo = 1'b1; A = 32'h22;
    @(negedge CLK);
    mtlo = 1'b0;
    check("mtlo_write", LO, 32'h22);
    run_op(OP_DIVU, 32'd5, 32'd0, 0, lat, nb, hk);
    check("div0_lat", lat, 34);
    check("div0_hi", HI, 32'h11);
    check("div0_lo", LO, 32'h22);

    // mthi and start mid-RUN are both ignored
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'h7, 1, lat, nb, hk);
    check("inject_lat", lat, 34);
    check("inject_hi", HI, 32'hFFFF_FFFF);
    check("inject_lo", LO, 32'hFFFF_FFEB);
    @(negedge CLK);
    check("inject_no_restart", {31'b0, busy}, 32'h0);

    // reset mid-multiply, then a fresh operation
    run_op(OP_MULT, 32'h1234_5678, 32'h9ABC_DEF0, 2, lat, nb, hk);
    check("rst_mid_taken", lat, -1);
    check("rst_mid_hi", HI, 32'h0);
    check("rst_mid_lo", LO, 32'h0);
    check("rst_mid_busy", {31'b0, busy}, 32'h0);
    check("rst_mid_done", {31'b0, done}, 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    run_op(OP_MULTU, 32'd3, 32'd5, 0, lat, nb, hk);
    check("post_rst_lo", LO, 32'd15);
    check("post_rst_hi", HI, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
